m6502_bus_ctrl: RTL and testbench
=================================

M6502_BUS_CTRL -- requirements
Module: m6502_bus_ctrl

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 0, extra wait cycles for RAM accesses (0..15).
REQ-002 SHALL have parameter ROM_WAIT, default 1, extra wait cycles for ROM accesses (0..15).
REQ-003 SHALL have parameter IO_TIMEOUT, default 15, maximum cycles to wait for io_ack (1..255).
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_rd_req  in  1  read request pulse from CPU
- cpu_wr_en  in  1  write request pulse from CPU
- cpu_wr_data  in  8  CPU write data
- cpu_rd_data  out  8  read data returned to CPU
- cpu_ready  out  1  high = idle / previous access complete
- mem_addr  out  16  latched access address
- mem_wr_data  out  8  latched write data
- mem_rd  out  1  read strobe, held for the access
- mem_wr  out  1  write strobe, held for the access
- ram_cs, rom_cs, io_cs  out  1 each  region selects, one-hot or all low
- ram_rd_data, rom_rd_data, io_rd_data  in  8 each  region read data
- io_ack  in  1  I/O device completion
- err_flags  out  3  sticky {io_timeout, rom_write, overrun}

Function
REQ-005 Address map: RAM 0x0000-0xBFFF, IO 0xC000-0xDFFF, ROM 0xE000-0xFFFF; decode on cpu_addr[15:13].
REQ-006 States: IDLE, ACCESS; cpu_ready SHALL be 1 exactly in IDLE.
REQ-007 IDLE, rising edge with cpu_rd_req or cpu_wr_en high: latch mem_addr, mem_wr_data, direction and region; assert the region cs and mem_rd/mem_wr; load the wait counter (RAM_WAIT, ROM_WAIT or IO_TIMEOUT); go to ACCESS; cpu_ready <= 0.
REQ-008 cpu_rd_req and cpu_wr_en both high at the same edge: the write SHALL be performed and the read dropped.
REQ-009 ACCESS, RAM/ROM: counter nonzero -> decrement; counter zero -> complete.
REQ-010 ACCESS, IO: io_ack high -> complete; else counter nonzero -> decrement; counter zero with io_ack low -> complete with read data 0xFF and set err_flags[2].
REQ-011 On complete: a read SHALL capture the selected region's data (or 0xFF on IO timeout) into cpu_rd_data; cs, mem_rd and mem_wr SHALL deassert; cpu_ready <= 1; return to IDLE.
REQ-012 A RAM access with wait 0 SHALL complete on the edge after the request edge; total latency is request edge + 1 + wait cycles.
REQ-013 cpu_rd_data SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-014 A write to ROM SHALL NOT assert mem_wr or rom_cs, SHALL still complete after ROM_WAIT cycles, and SHALL set err_flags[1].
REQ-015 cpu_rd_req or cpu_wr_en high during ACCESS SHALL be ignored and SHALL set err_flags[0]; the in-flight access is unaffected.
REQ-016 mem_addr and mem_wr_data SHALL stay stable from request edge through completion.
REQ-017 err_flags bits SHALL be sticky and cleared only by reset.

Reset
REQ-018 While reset is high: state IDLE, cpu_ready=1, cpu_rd_data=0x00, mem_addr=0x0000, mem_wr_data=0x00, all strobes and cs=0, err_flags=0, counter=0.
REQ-019 Reset asserted mid-access SHALL drop all strobes asynchronously; no data capture; after release the block accepts a new request on the next edge.

Verification
REQ-020 RAM read, RAM_WAIT=0: ram_rd_data=0x5A, cpu_rd_req at 0x0200 -> ram_cs+mem_rd one cycle, cpu_ready low one cycle, cpu_rd_data=0x5A.
REQ-021 Reset-vector read, ROM_WAIT=1: read 0xFFFC with rom_rd_data=0x00 then 0xFFFD with 0xE0 -> each takes 2 cycles in ACCESS, cpu_rd_data 0x00 then 0xE0.
REQ-022 IO write 0x33 to 0xD010, io_ack after 3 cycles -> mem_wr+io_cs held 3 cycles, mem_wr_data=0x33, completes on ack, err_flags=0.
REQ-023 IO read 0xC000, io_ack never -> completes after IO_TIMEOUT, cpu_rd_data=0xFF, err_flags=3'b100.
REQ-024 Write to 0xF000 -> no mem_wr, no rom_cs, ready returns after ROM_WAIT+1, err_flags[1]=1; request during ACCESS -> err_flags[0]=1, original access unaltered.
REQ-025 Reset pulse during IO ACCESS -> strobes low immediately, cpu_ready=1, cpu_rd_data=0x00; next RAM read completes normally.

Source files
------------

// File: rtl/m6502_bus_ctrl.sv
// 6502-style bus controller: decodes CPU accesses into RAM / IO / ROM cycles,
// inserts per-region wait states, times out silent IO devices and keeps sticky error flags.
module m6502_bus_ctrl #(
   parameter int RAM_WAIT   = 0,
   parameter int ROM_WAIT   = 1,
   parameter int IO_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rd_req,
   input  logic        cpu_wr_en,
   input  logic [7:0]  cpu_wr_data,
   output logic [7:0]  cpu_rd_data,
   output logic        cpu_ready,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wr_data,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        ram_cs,
   output logic        rom_cs,
   output logic        io_cs,
   input  logic [7:0]  ram_rd_data,
   input  logic [7:0]  rom_rd_data,
   input  logic [7:0]  io_rd_data,
   input  logic        io_ack,
   output logic [2:0]  err_flags
);

   typedef enum logic {IDLE, ACCESS} state_t;
   typedef enum logic [1:0] {REG_RAM, REG_IO, REG_ROM} region_t;

   state_t      state_q, state_d;
   region_t     region_q, region_d, reqRegion;
   logic        isWrite_q, isWrite_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wrData_q, wrData_d;
   logic [7:0]  rdData_q, rdData_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  err_q, err_d;
   logic        cpuReq;

   assign cpuReq = cpu_rd_req | cpu_wr_en;

   always_comb begin
      case (cpu_addr[15:13])
         3'b110:  reqRegion = REG_IO;
         3'b111:  reqRegion = REG_ROM;
         default: reqRegion = REG_RAM;
      endcase
   end

   // A simultaneous read and write request is taken as a write; the IO counter
   // doubles as the ack timeout, so an expired IO access returns 0xFF.
   always_comb begin
      state_d   = state_q;
      region_d  = region_q;
      isWrite_d = isWrite_q;
      addr_d    = addr_q;
      wrData_d  = wrData_q;
      rdData_d  = rdData_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (cpuReq) begin
               state_d   = ACCESS;
               region_d  = reqRegion;
               isWrite_d = cpu_wr_en;
               addr_d    = cpu_addr;
               wrData_d  = cpu_wr_data;
               case (reqRegion)
                  REG_IO:  cnt_d = 8'(IO_TIMEOUT);
                  REG_ROM: cnt_d = 8'(ROM_WAIT);
                  default: cnt_d = 8'(RAM_WAIT);
               endcase
               if (cpu_wr_en && reqRegion == REG_ROM) err_d[1] = 1'b1;
            end
         end
         ACCESS: begin
            if (cpuReq) err_d[0] = 1'b1;
            if (region_q == REG_IO && io_ack) begin
               state_d = IDLE;
               if (!isWrite_q) rdData_d = io_rd_data;
            end else if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = IDLE;
               if (region_q == REG_IO) err_d[2] = 1'b1;
               if (!isWrite_q) begin
                  case (region_q)
                     REG_IO:  rdData_d = 8'hFF;
                     REG_ROM: rdData_d = rom_rd_data;
                     default: rdData_d = ram_rd_data;
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         region_q  <= REG_RAM;
         isWrite_q <= 1'b0;
         addr_q    <= 16'h0000;
         wrData_q  <= 8'h00;
         rdData_q  <= 8'h00;
         cnt_q     <= 8'h00;
         err_q     <= 3'b000;
      end else begin
         state_q   <= state_d;
         region_q  <= region_d;
         isWrite_q <= isWrite_d;
         addr_q    <= addr_d;
         wrData_q  <= wrData_d;
         rdData_q  <= rdData_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   // Strobes derive from the registered state, so reset drops them immediately;
   // ROM writes are swallowed without touching the bus.
   assign cpu_ready   = (state_q == IDLE);
   assign cpu_rd_data = rdData_q;
   assign mem_addr    = addr_q;
   assign mem_wr_data = wrData_q;
   assign err_flags   = err_q;
   assign mem_rd      = (state_q == ACCESS) && !isWrite_q;
   assign mem_wr      = (state_q == ACCESS) && isWrite_q && (region_q != REG_ROM);
   assign ram_cs      = (state_q == ACCESS) && (region_q == REG_RAM);
   assign io_cs       = (state_q == ACCESS) && (region_q == REG_IO);
   assign rom_cs      = (state_q == ACCESS) && (region_q == REG_ROM) && !isWrite_q;

endmodule

// File: tb/tb_m6502_bus_ctrl.sv
// Directed self-checking bench for m6502_bus_ctrl with default wait parameters
// (RAM 0, ROM 1, IO timeout 15); expected values are worked out by hand.
module tb_m6502_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic        cpu_rd_req;
   logic        cpu_wr_en;
   logic [7:0]  cpu_wr_data;
   logic [7:0]  cpu_rd_data;
   logic        cpu_ready;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wr_data;
   logic        mem_rd;
   logic        mem_wr;
   logic        ram_cs;
   logic        rom_cs;
   logic        io_cs;
   logic [7:0]  ram_rd_data;
   logic [7:0]  rom_rd_data;
   logic [7:0]  io_rd_data;
   logic        io_ack;
   logic [2:0]  err_flags;

   int checkCount = 0;
   int passCount  = 0;
   int lowCycles;

   m6502_bus_ctrl #(.RAM_WAIT(0), .ROM_WAIT(1), .IO_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_rd_req(cpu_rd_req), .cpu_wr_en(cpu_wr_en),
      .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .ram_cs(ram_cs), .rom_cs(rom_cs), .io_cs(io_cs),
      .ram_rd_data(ram_rd_data), .rom_rd_data(rom_rd_data), .io_rd_data(io_rd_data),
      .io_ack(io_ack), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
   endtask

   // One clock: inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic startRequest(input logic [15:0] addr, input logic rd, input logic wr, input logic [7:0] data);
      cpu_addr = addr; cpu_rd_req = rd; cpu_wr_en = wr; cpu_wr_data = data;
      applyStimulus();
      cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cpu_addr = 16'h0000; cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
      cpu_wr_data = 8'h00; ram_rd_data = 8'h00; rom_rd_data = 8'h00;
      io_rd_data = 8'h00; io_ack = 1'b0;
      #12;
      checkOutput("rst_ready", 16'(cpu_ready), 16'h1);
      checkOutput("rst_rdata", 16'(cpu_rd_data), 16'h00);
      checkOutput("rst_addr", mem_addr, 16'h0000);
      checkOutput("rst_strobes", 16'({mem_rd, mem_wr, ram_cs, rom_cs, io_cs}), 16'h0);
      checkOutput("rst_err", 16'(err_flags), 16'h0);
      @(negedge clk); reset = 1'b0;
      applyStimulus();

      // RAM read, zero wait
      ram_rd_data = 8'h5A;
      startRequest(16'h0200, 1'b1, 1'b0, 8'h00);
      checkOutput("ram_acc_ready", 16'(cpu_ready), 16'h0);
      checkOutput("ram_acc_cs_rd", 16'({ram_cs, mem_rd, rom_cs, io_cs, mem_wr}), 16'b11000);
      checkOutput("ram_acc_addr", mem_addr, 16'h0200);
      applyStimulus();
      checkOutput("ram_done_ready", 16'(cpu_ready), 16'h1);
      checkOutput("ram_done_cs", 16'({ram_cs, mem_rd}), 16'h0);
      checkOutput("ram_rdata", 16'(cpu_rd_data), 16'h5A);

      // Reset vector fetch, two cycles each in ACCESS
      rom_rd_data = 8'h00;
      startRequest(16'hFFFC, 1'b1, 1'b0, 8'h00);
      checkOutput("vec_lo_cs1", 16'({rom_cs, mem_rd, cpu_ready}), 16'b110);
      applyStimulus();
      checkOutput("vec_lo_cs2", 16'({rom_cs, mem_rd, cpu_ready}), 16'b110);
      applyStimulus();
      checkOutput("vec_lo_ready", 16'(cpu_ready), 16'h1);
      checkOutput("vec_lo_data", 16'(cpu_rd_data), 16'h00);
      rom_rd_data = 8'hE0;
      startRequest(16'hFFFD, 1'b1, 1'b0, 8'h00);
      applyStimulus();
      checkOutput("vec_hi_wait", 16'(cpu_ready), 16'h0);
      applyStimulus();
      checkOutput("vec_hi_ready", 16'(cpu_ready), 16'h1);
      checkOutput("vec_hi_data", 16'(cpu_rd_data), 16'hE0);

      // IO write acknowledged after three cycles; CPU data changes underneath
      startRequest(16'hD010, 1'b0, 1'b1, 8'h33);
      cpu_wr_data = 8'h00;
      checkOutput("io_wr_c1", 16'({io_cs, mem_wr, mem_rd}), 16'b110);
      checkOutput("io_wr_data", 16'(mem_wr_data), 16'h33);
      applyStimulus();
      checkOutput("io_wr_c2", 16'({io_cs, mem_wr}), 16'b11);
      applyStimulus();
      checkOutput("io_wr_c3", 16'({io_cs, mem_wr}), 16'b11);
      checkOutput("io_wr_hold", {mem_addr[7:0], mem_wr_data}, 16'h1033);
      io_ack = 1'b1;
      applyStimulus();
      io_ack = 1'b0;
      checkOutput("io_wr_done", 16'({cpu_ready, io_cs, mem_wr}), 16'b100);
      checkOutput("io_wr_err", 16'(err_flags), 16'h0);
      checkOutput("io_wr_rdata", 16'(cpu_rd_data), 16'hE0);

      // IO read with no ack: ready stays low for IO_TIMEOUT+1 cycles
      io_rd_data = 8'h12;
      startRequest(16'hC000, 1'b1, 1'b0, 8'h00);
      lowCycles = 0;
      for (int i = 0; i < 40 && !cpu_ready; i++) begin
         lowCycles++;
         applyStimulus();
      end
      checkOutput("io_to_cycles", 16'(lowCycles), 16'd16);
      checkOutput("io_to_rdata", 16'(cpu_rd_data), 16'hFF);
      checkOutput("io_to_err", 16'(err_flags), 16'b100);

      // Reset clears sticky flags
      reset = 1'b1; #3;
      checkOutput("err_cleared", 16'(err_flags), 16'h0);
      @(negedge clk); reset = 1'b0;
      applyStimulus();

      // ROM write with an overrun request in the middle
      startRequest(16'hF000, 1'b0, 1'b1, 8'h99);
      checkOutput("romwr_bus", 16'({rom_cs, mem_wr, cpu_ready}), 16'b000);
      checkOutput("romwr_err1", 16'(err_flags), 16'b010);
      cpu_addr = 16'h0100; cpu_rd_req = 1'b1;
      applyStimulus();
      cpu_rd_req = 1'b0;
      checkOutput("romwr_addr", mem_addr, 16'hF000);
      checkOutput("romwr_wait", 16'({cpu_ready, ram_cs, rom_cs}), 16'b000);
      applyStimulus();
      checkOutput("romwr_ready", 16'(cpu_ready), 16'h1);
      checkOutput("romwr_err", 16'(err_flags), 16'b011);

      // Reset during an IO access
      ram_rd_data = 8'h77;
      startRequest(16'h0010, 1'b1, 1'b0, 8'h00);
      applyStimulus();
      checkOutput("pre_rst_data", 16'(cpu_rd_data), 16'h77);
      startRequest(16'hC000, 1'b1, 1'b0, 8'h00);
      checkOutput("mid_io_cs", 16'({io_cs, mem_rd}), 16'b11);
      #2 reset = 1'b1;
      #1;
      checkOutput("mid_rst_strobes", 16'({io_cs, mem_rd, cpu_ready}), 16'b001);
      checkOutput("mid_rst_rdata", 16'(cpu_rd_data), 16'h00);
      @(negedge clk); reset = 1'b0;
      ram_rd_data = 8'hA5;
      startRequest(16'h1234, 1'b1, 1'b0, 8'h00);
      checkOutput("post_rst_cs", 16'({ram_cs, mem_rd, cpu_ready}), 16'b110);
      applyStimulus();
      checkOutput("post_rst_data", {7'(0), cpu_ready, cpu_rd_data}, 16'h01A5);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
